// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared types and default sizes for the multi-channel PWM.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Counting scheme of the shared period counter
    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_t;

    // Counter direction (only meaningful in centre-aligned mode)
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam int PWM_WIDTH_DEFAULT    = 16;
    localparam int PWM_CHANNELS_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module      : pwm_channel
// Description : One PWM compare channel: shadow/active compare, comparison
//               against the shared counter, polarity and output register.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             enable,
    input  logic             load,
    input  logic             xfer,
    input  logic             polarity,
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] compare_in,
    output logic             line
);

    logic [WIDTH-1:0] shadow_cmp;
    logic [WIDTH-1:0] active_cmp;
    logic [WIDTH-1:0] eff_cmp;
    logic             raw;

    // In a transfer cycle the comparison already uses the incoming value, so
    // the new duty shows on line together with tc/applied.
    assign eff_cmp = xfer ? shadow_cmp : active_cmp;
    assign raw     = (count < eff_cmp);

    // Shadow compare captures the host value on every load strobe
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shadow_cmp <= '0;
        end else if (load) begin
            shadow_cmp <= compare_in;
        end
    end

    // Active compare follows the shadow only on a transfer strobe
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            active_cmp <= '0;
        end else if (xfer) begin
            active_cmp <= shadow_cmp;
        end
    end

    // Registered output; inactive level (= polarity) while halted
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            line <= 1'b0;
        end else if (enable) begin
            line <= raw ^ polarity;
        end else begin
            line <= polarity;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi
// Description : Multi-channel PWM generator with one shared period counter,
//               edge- or centre-aligned counting and double-buffered
//               period/compare values applied at period boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH    = PWM_WIDTH_DEFAULT,
    parameter int CHANNELS = PWM_CHANNELS_DEFAULT
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      enable,
    input  pwm_mode_t                 mode,
    input  logic                      load,
    input  logic [WIDTH-1:0]          period_in,
    input  logic [CHANNELS*WIDTH-1:0] compare_in,
    input  logic [CHANNELS-1:0]       polarity,
    output logic [CHANNELS-1:0]       line,
    output logic                      tc,
    output logic                      applied,
    output logic [WIDTH-1:0]          count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next;
    dir_t             dir_r;
    dir_t             dir_next;
    pwm_mode_t        mode_r;
    logic [WIDTH-1:0] shadow_period;
    logic [WIDTH-1:0] active_period;
    logic [WIDTH-1:0] eff_period;
    logic             pending;
    logic             at_zero;
    logic             boundary;
    logic             xfer;

    // A running counter sits at zero only in the first cycle of a period,
    // in both modes, so that is the boundary cycle.
    assign at_zero  = (count_r == '0);
    assign boundary = enable && at_zero;
    // While halted a pending shadow is pushed through on the next clock.
    assign xfer     = pending && (!enable || at_zero);
    // The new period governs the counting that starts in the boundary cycle.
    assign eff_period = xfer ? shadow_period : active_period;

    // Counter / direction state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count_r <= '0;
            dir_r   <= DIR_UP;
        end else begin
            count_r <= count_next;
            dir_r   <= dir_next;
        end
    end

    // Next-state logic of the counter and its direction
    always_comb begin
        count_next = count_r;
        dir_next   = dir_r;
        if (!enable) begin
            count_next = '0;
            dir_next   = DIR_UP;
        end else if (at_zero) begin
            dir_next   = DIR_UP;
            count_next = (eff_period != '0) ? ONE : '0;
        end else if (mode_r == PWM_EDGE) begin
            count_next = (count_r >= eff_period) ? '0 : count_r + ONE;
        end else if (dir_r == DIR_UP) begin
            if (count_r >= eff_period) begin
                count_next = count_r - ONE;
                dir_next   = DIR_DOWN;
            end else begin
                count_next = count_r + ONE;
            end
        end else begin
            count_next = count_r - ONE;
        end
    end

    // Output decode of the counter state
    always_comb begin
        count = count_r;
    end

    // Counting mode is only latched while halted
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mode_r <= PWM_EDGE;
        end else if (!enable) begin
            mode_r <= mode;
        end
    end

    // Period double buffer and pending flag; a load in a transfer cycle
    // stays pending because the transfer reads the old shadow.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shadow_period <= '0;
            active_period <= '0;
            pending       <= 1'b0;
        end else begin
            if (load) begin
                shadow_period <= period_in;
            end
            if (xfer) begin
                active_period <= shadow_period;
            end
            if (load) begin
                pending <= 1'b1;
            end else if (xfer) begin
                pending <= 1'b0;
            end
        end
    end

    // Registered period-start and transfer-done pulses
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tc      <= 1'b0;
            applied <= 1'b0;
        end else begin
            tc      <= boundary;
            applied <= xfer;
        end
    end

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
            pwm_channel #(
                .WIDTH (WIDTH)
            ) u_channel (
                .clk        (clk),
                .nrst       (nrst),
                .enable     (enable),
                .load       (load),
                .xfer       (xfer),
                .polarity   (polarity[i]),
                .count      (count_r),
                .compare_in (compare_in[i*WIDTH +: WIDTH]),
                .line       (line[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_multi
// Description : Self-checking bench for pwm_multi against a phase-index
//               reference model, with directed duty/tc tallies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multi;
    import pwm_pkg::*;

    localparam int W  = 8;
    localparam int CH = 4;

    logic            clk = 1'b0;
    logic            nrst;
    logic            enable;
    pwm_mode_t       mode;
    logic            load;
    logic [W-1:0]    period_in;
    logic [CH*W-1:0] compare_in;
    logic [CH-1:0]   polarity;
    logic [CH-1:0]   line;
    logic            tc;
    logic            applied;
    logic [W-1:0]    count;

    pwm_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .enable     (enable),
        .mode       (mode),
        .load       (load),
        .period_in  (period_in),
        .compare_in (compare_in),
        .polarity   (polarity),
        .line       (line),
        .tc         (tc),
        .applied    (applied),
        .count      (count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // stimulus values for the next cycle
    bit          en_v, ld_v, mode_v;
    int          p_v;
    int          c_v [CH];
    bit [CH-1:0] pol_v;

    // reference model: position within the period as a plain index
    int  m_phase, m_sp, m_ap;
    int  m_sc [CH];
    int  m_ac [CH];
    bit  m_pend, m_center;
    bit [CH-1:0] e_line;
    bit  e_tc, e_app;
    int  e_count;

    // tallies of DUT outputs for directed checks
    int  hi [CH];
    int  tc_cnt, app_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int period_len(input int p, input bit ctr);
        if (!ctr) return p + 1;
        return (p == 0) ? 1 : 2 * p;
    endfunction

    function automatic int count_at(input int k, input int p, input bit ctr);
        if (!ctr || k <= p) return k;
        return 2 * p - k;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_sp = 0; m_ap = 0; m_pend = 0; m_center = 0;
        for (int i = 0; i < CH; i++) begin
            m_sc[i] = 0; m_ac[i] = 0;
        end
    endtask

    task automatic model_step();
        bit xf, bnd;
        int cnt, ec;
        xf  = m_pend && (!en_v || m_phase == 0);
        bnd = en_v && (m_phase == 0);
        cnt = count_at(m_phase, m_ap, m_center);
        for (int i = 0; i < CH; i++) begin
            ec = xf ? m_sc[i] : m_ac[i];
            e_line[i] = en_v ? ((cnt < ec) ^ pol_v[i]) : pol_v[i];
        end
        e_tc  = bnd;
        e_app = xf;
        if (xf) begin
            m_ap = m_sp;
            for (int i = 0; i < CH; i++) m_ac[i] = m_sc[i];
        end
        if (ld_v) begin
            m_sp = p_v;
            for (int i = 0; i < CH; i++) m_sc[i] = c_v[i];
            m_pend = 1;
        end else if (xf) begin
            m_pend = 0;
        end
        if (!en_v) begin
            m_phase  = 0;
            m_center = mode_v;
        end else begin
            m_phase = (m_phase + 1) % period_len(m_ap, m_center);
        end
        e_count = count_at(m_phase, m_ap, m_center);
    endtask

    task automatic clr();
        for (int i = 0; i < CH; i++) hi[i] = 0;
        tc_cnt = 0; app_cnt = 0;
    endtask

    // drive one cycle (called away from the clock edge), then check
    task automatic cycle();
        enable    = en_v;
        load      = ld_v;
        mode      = pwm_mode_t'(mode_v);
        period_in = W'(p_v);
        polarity  = pol_v;
        for (int i = 0; i < CH; i++) compare_in[i*W +: W] = W'(c_v[i]);
        model_step();
        @(posedge clk);
        #1;
        check("count",   32'(count),   32'(e_count));
        check("tc",      32'(tc),      32'(e_tc));
        check("applied", 32'(applied), 32'(e_app));
        check("line",    32'(line),    32'(e_line));
        for (int i = 0; i < CH; i++) hi[i] += int'(line[i]);
        tc_cnt  += int'(tc);
        app_cnt += int'(applied);
        ld_v = 0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic set_load(input int p, input int c0, input int c1, input int c2, input int c3);
        ld_v = 1; p_v = p;
        c_v[0] = c0; c_v[1] = c1; c_v[2] = c2; c_v[3] = c3;
    endtask

    task automatic wait_phase(input int ph);
        for (int k = 0; k < 200 && m_phase != ph; k++) cycle();
    endtask

    task automatic wait_applied();
        for (int k = 0; k < 200 && m_pend; k++) cycle();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0; enable = 0; load = 0; mode = PWM_EDGE;
        period_in = '0; compare_in = '0; polarity = '0;
        en_v = 0; ld_v = 0; mode_v = 0; p_v = 0; pol_v = '0;
        for (int i = 0; i < CH; i++) c_v[i] = 0;
        model_reset();
        clr();
        #2;
        check("rst_line",    32'(line),    0);
        check("rst_tc",      32'(tc),      0);
        check("rst_applied", 32'(applied), 0);
        check("rst_count",   32'(count),   0);
        #1 nrst = 1'b1;

        // edge mode, P=9
        set_load(9, 3, 0, 10, 5);
        run(2);
        en_v = 1;
        run(3);
        clr(); run(20);
        check("edge_hi0",  hi[0], 6);
        check("edge_tc",   tc_cnt, 2);
        check("edge_c0",   hi[1], 0);
        check("edge_cmax", hi[2], 20);

        pol_v = 4'b1111;
        clr(); run(20);
        check("inv_hi0",  hi[0], 14);
        check("inv_c0",   hi[1], 20);
        check("inv_cmax", hi[2], 0);
        pol_v = '0;

        // mid-period load at count 5
        wait_phase(5);
        set_load(4, 2, 0, 10, 5);
        cycle();
        wait_applied();
        clr(); run(10);
        check("mid_hi0", hi[0], 4);
        check("mid_tc",  tc_cnt, 2);

        // load exactly in a boundary cycle waits one full period
        wait_phase(0);
        set_load(6, 1, 0, 10, 5);
        cycle();
        clr(); run(4);
        check("bnd_load_hold", app_cnt, 0);
        cycle();
        check("bnd_load_apply", 32'(applied), 1);

        // P = 0: every cycle is a period start
        set_load(0, 3, 0, 10, 5);
        cycle();
        wait_applied();
        clr(); run(5);
        check("p0_tc", tc_cnt, 5);
        check("p0_hi2", hi[2], 5);

        // centre mode, P=8
        en_v = 0; mode_v = 1;
        set_load(8, 3, 4, 0, 9);
        run(2);
        en_v = 1;
        run(1);
        clr(); run(32);
        check("ctr_tc",  tc_cnt, 2);
        check("ctr_hi0", hi[0], 10);
        check("ctr_hi1", hi[1], 14);
        check("ctr_c0",  hi[2], 0);
        check("ctr_max", hi[3], 32);

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) < 3) en_v = ~en_v;
            mode_v = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 6) begin
                ld_v = 1;
                p_v  = int'($urandom_range(0, 12));
                for (int i = 0; i < CH; i++) c_v[i] = int'($urandom_range(0, 14));
            end
            if ($urandom_range(0, 99) < 5) pol_v = CH'($urandom);
            cycle();
        end

        // enable dropped mid-period, then reset with a pending shadow
        en_v = 0; mode_v = 0; pol_v = 4'b0101;
        set_load(9, 3, 5, 7, 1);
        run(2);
        en_v = 1;
        run(4);
        en_v = 0;
        cycle();
        check("halt_line",  32'(line),  32'(4'b0101));
        check("halt_count", 32'(count), 0);
        en_v = 1;
        run(4);
        set_load(5, 2, 2, 2, 2);
        cycle();
        cycle();
        nrst = 1'b0;
        #1;
        check("arst_line",    32'(line),    0);
        check("arst_tc",      32'(tc),      0);
        check("arst_applied", 32'(applied), 0);
        check("arst_count",   32'(count),   0);
        model_reset();
        #1 nrst = 1'b1;
        clr(); run(30);
        check("arst_no_apply", app_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
